// File: rtl/ysyx_22050243_pkg.sv
// Shared GPR geometry and write-back source identifiers for the ysyx_22050243 core.
package ysyx_22050243_pkg;

    localparam int GPR_ADDR_WIDTH = 5;
    localparam int GPR_DATA_WIDTH = 64;
    localparam int GPR_NUM        = 2 ** GPR_ADDR_WIDTH;

    localparam logic WB_SRC_EXU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

endpackage : ysyx_22050243_pkg

// File: rtl/ysyx_22050243_arb2.sv
// Two-way write-back arbiter (EXU vs LSU). Round-robin when YSYX_22050243_WB_RR_EN
// is defined, otherwise fixed priority with LSU over EXU.
module ysyx_22050243_arb2
    import ysyx_22050243_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic exu_req_i,
    input  logic lsu_req_i,
    output logic exu_gnt_o,
    output logic lsu_gnt_o
);

`ifdef YSYX_22050243_WB_RR_EN
    logic last_q;
    logic last_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        exu_gnt_o = 1'b0;
        lsu_gnt_o = 1'b0;
        last_d    = last_q;
        if (exu_req_i && lsu_req_i) begin
            if (last_q == WB_SRC_EXU) lsu_gnt_o = 1'b1;
            else                      exu_gnt_o = 1'b1;
        end else begin
            exu_gnt_o = exu_req_i;
            lsu_gnt_o = lsu_req_i;
        end
        // The write stage never back-pressures, so every grant is a handshake.
        if (exu_gnt_o)      last_d = WB_SRC_EXU;
        else if (lsu_gnt_o) last_d = WB_SRC_LSU;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= WB_SRC_LSU;   // "last was LSU" makes EXU the first preferred winner
        else        last_q <= last_d;
    end
`else
    assign lsu_gnt_o = lsu_req_i;
    assign exu_gnt_o = exu_req_i & ~lsu_req_i;

    // Fixed priority is stateless; the clock and reset ports are kept for a uniform interface.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule : ysyx_22050243_arb2

// File: rtl/ysyx_22050243_gpr_wb_sched.sv
// GPR write-back scheduler: arbitrates EXU/LSU onto one registered write port and keeps a
// busy scoreboard that stalls issue on RAW/WAW hazards. Arbitration mode: YSYX_22050243_WB_RR_EN.
module ysyx_22050243_gpr_wb_sched
    import ysyx_22050243_pkg::*;
#(
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int NUM_REGS   = GPR_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic                  iss_wr,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  iss_rs1_en,
    input  logic                  iss_rs2_en,
    input  logic [ADDR_WIDTH-1:0] iss_rs1,
    input  logic [ADDR_WIDTH-1:0] iss_rs2,
    output logic                  stall,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data
);

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

    logic                  wb_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  iss_fire;

    // Requests are masked during reset so no grant is issued while the pipeline is being cleared.
    ysyx_22050243_arb2 u_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .exu_req_i (exu_valid & rst_n),
        .lsu_req_i (lsu_valid & rst_n),
        .exu_gnt_o (exu_ready),
        .lsu_gnt_o (lsu_ready)
    );

    assign wb_fire = exu_ready | lsu_ready;
    assign wb_rd   = lsu_ready ? lsu_rd   : exu_rd;
    assign wb_data = lsu_ready ? lsu_data : exu_data;

    assign stall = iss_valid & ((iss_rs1_en & busy_q[iss_rs1]) |
                                (iss_rs2_en & busy_q[iss_rs2]) |
                                (iss_wr     & busy_q[iss_rd]));

    assign iss_fire = iss_valid & ~stall & iss_wr & (iss_rd != '0);

    always_comb begin
        busy_d = busy_q;
        if (wb_fire)  busy_d[wb_rd]  = 1'b0;
        if (iss_fire) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;

        w_en_d   = wb_fire & (wb_rd != '0);
        w_addr_d = wb_fire ? wb_rd   : w_addr_q;
        w_data_d = wb_fire ? wb_data : w_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            busy_q   <= busy_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign w_en   = w_en_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;

endmodule : ysyx_22050243_gpr_wb_sched
